// File: rtl/rx_fsm_if.sv
// Serial-line and received-byte bundle for the UART receive engine.
// The master side drives RX and consumes the byte/strobes; rx_fsm sits on the slave side.
interface rx_fsm_if;
    logic       RX;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output RX,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  RX,
        output data_out,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/rx_fsm.sv
// UART 8N1 receive engine: synchronises RX, samples each bit at mid-bit with a
// baud counter, and presents the byte with a one-cycle data_valid or frame_error strobe.
module rx_fsm #(
    parameter int unsigned clk_freq_Hz = 1000000,
    parameter int unsigned baud_rate   = 9600
) (
    input  logic     clk,
    input  logic     RSTn,
    rx_fsm_if.slave  bus
);

    localparam int unsigned CLKS_PER_BIT = clk_freq_Hz / baud_rate;
    localparam int unsigned HALF         = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, rx_s_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_error_q, frame_error_d;
    logic               busy_q;
    logic               start_tick_c;
    logic               bit_tick_c;

    // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= bus.RX;
            rx_s_q  <= sync1_q;
        end
    end

    assign start_tick_c = (cnt_q == CNT_W'(HALF));
    assign bit_tick_c   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (start_tick_c) state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick_c && (idx_q == IDX_W'(7))) state_d = STOP;
            end
            STOP: begin
                if (bit_tick_c) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and strobe next values; the counter also restarts at each data-bit boundary.
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == DATA) && bit_tick_c) begin
            cnt_d = '0;
        end

        case (state_q)
            START: begin
                idx_d = '0;
            end
            DATA: begin
                if (bit_tick_c) begin
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + IDX_W'(1);
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    if (rx_s_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = busy_q;

endmodule
